multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared instruction/data memory port with a ready handshake. It drives the existing datapath control signals (reg_wen, reg_des, dmem_alu, mem_wen, jr, alu_sel, alu_code) plus the PC/IR enables. It replaces single-cycle control when the core runs against one single-port memory.

## Interface
- TIMEOUT, 255: maximum consecutive wait cycles on one memory request before halting (1..255).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ins  in  32  current instruction register contents.
- mem_ready  in  1  memory completes the outstanding request this cycle.
- mem_req  out  1  memory request valid.
- mem_iord  out  1  0 = instruction address (PC), 1 = data address (ALU result).
- mem_wen  out  1  memory write; valid only with mem_req.
- pc_wen  out  1  PC update strobe.
- ir_wen  out  1  instruction register load strobe.
- reg_wen  out  1  register file write strobe.
- reg_des  out  1  0 = rd, 1 = rt.
- dmem_alu  out  1  writeback source: 0 = ALU, 1 = memory.
- alu_sel  out  1  ALU B operand: 0 = rt, 1 = immediate.
- jr  out  1  PC source is rs.
- alu_code  out  5  ALU operation.
- state  out  3  current state, for debug.
- halted  out  1  sticky; set on an illegal opcode or a timeout.
- timeout  out  1  sticky; the halt cause was a memory timeout.
- retired  out  32  count of completed instructions; wraps modulo 2^32.

## Operation
- Decode rules:
  - R-type (op 0) functs and their alu_code: add 0, addu 1, sub 2, subu 3, and 4, or 5, nor 6, slt 7, sll 8, srl 9, sra 10, jr 11.
  - ins == 0 is a nop.
  - I-type opcodes and their alu_code: andi 0x0C→13, ori 0x0D→14, slti 0x0A→15, addi 0x08→16, addiu 0x09→17, lw 0x23→18, sw 0x2B→19, lui 0x0F→20.
  - Anything else, including an unlisted R-type funct, is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - Outputs: mem_req=1, mem_iord=0.
  - On mem_ready: ir_wen=1 and pc_wen=1 (PC+4) in that cycle, then go to DECODE.
- DECODE:
  - illegal → HALT, set halted.
  - nop → FETCH, retired+1.
  - All other instructions → EXEC.
- EXEC:
  - jr: pc_wen=1, jr=1, then FETCH with retired+1.
  - lw/sw → MEM.
  - ALU class → WB.
- MEM:
  - Outputs: mem_req=1, mem_iord=1; mem_wen=1 for sw.
  - On mem_ready: sw → FETCH with retired+1; lw → WB.
- WB: reg_wen=1 for exactly one cycle (dmem_alu=1 for lw), then FETCH with retired+1.
- HALT: all strobes 0; the FSM leaves HALT only on rst.
- Static controls during DECODE, EXEC, MEM and WB:
  - reg_des, alu_sel, alu_code and dmem_alu hold the decoded values for the whole instruction.
  - R-type: reg_des=0, alu_sel=0.
  - I-type: reg_des=1, alu_sel=1.
- In FETCH and HALT all static controls are 0.
- Wait counter (8 bits):
  - Increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on a state change.
  - When it reaches TIMEOUT: go to HALT, set halted=1 and timeout=1.
- mem_ready is ignored when mem_req=0.

## Timing
- While rst=1, and on the edge where rst is sampled high:
  - state=FETCH; all outputs 0; retired, the wait counter, halted and timeout cleared.
  - mem_req is forced 0 while rst=1.
  - The first request appears in the first cycle with rst=0.
- Rst asserted mid-instruction: no strobe in that cycle; abort to FETCH on the next edge.
- mem_ready in the same cycle as mem_req completes the access (zero-wait).
- Zero-wait cycles per instruction: nop 2, jr 3, R/I ALU 4, sw 4, lw 5. Each wait cycle adds 1.
- All strobes are single-cycle: pc_wen, ir_wen, reg_wen, and mem_wen qualified by mem_ready.
- retired increments on the edge leaving the final state of an instruction; halting does not count.
- A timeout and mem_ready in the same cycle: mem_ready wins.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - the instruction class enum (ALU_R, ALU_I, LW, SW, JR, NOP, ILLEGAL);
  - opcode/funct constants;
  - alu_code constants 0–20.
- Sub-module ins_class: purely combinational; ins → class, alu_code, reg_des, alu_sel, dmem_alu.
- The top level holds the FSM, the wait counter, the retired counter and the sticky flags.

## Test plan
- Reset, then addu $3,$1,$2 (0x00221821) with mem_ready held 1:
  - states 0,1,2,4; reg_wen high only in cycle 4; alu_code=1, reg_des=0; retired=1.
- lw 0x8C220004 with mem_ready delayed 3 cycles in MEM:
  - mem_iord=1 for 4 cycles; WB has dmem_alu=1, reg_wen=1; total 8 cycles.
- sw 0xAC220004: mem_wen=1 only in MEM with mem_req; reg_wen never 1; 4 cycles.
- jr $31 (0x03E00008) then nop (0x00000000):
  - jr=1 and pc_wen=1 in EXEC; the nop retires in 2 cycles; retired=2.
- Opcode 0x3F: HALT after DECODE, halted=1; further mem_ready pulses have no effect; rst returns to FETCH.
- TIMEOUT=4 with mem_ready held 0 in FETCH: HALT after 4 wait cycles, timeout=1, retired unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer.
// Contents:
//   state_t      FSM state encoding, also exported on the debug state port.
//   ins_class_t  instruction class produced by the decoder.
//   OP_* / FN_*  opcode and R-type funct field values.
//   AC_*         alu_code values driven to the datapath ALU.
//   uses_mem()   true for classes that need a data memory access.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        LW      = 3'd2,
        SW      = 3'd3,
        JR      = 3'd4,
        NOP     = 3'd5,
        ILLEGAL = 3'd6
    } ins_class_t;

    // Opcode field values (ins[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field values (ins[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operation codes understood by the datapath
    localparam logic [4:0] AC_ADD   = 5'd0;
    localparam logic [4:0] AC_ADDU  = 5'd1;
    localparam logic [4:0] AC_SUB   = 5'd2;
    localparam logic [4:0] AC_SUBU  = 5'd3;
    localparam logic [4:0] AC_AND   = 5'd4;
    localparam logic [4:0] AC_OR    = 5'd5;
    localparam logic [4:0] AC_NOR   = 5'd6;
    localparam logic [4:0] AC_SLT   = 5'd7;
    localparam logic [4:0] AC_SLL   = 5'd8;
    localparam logic [4:0] AC_SRL   = 5'd9;
    localparam logic [4:0] AC_SRA   = 5'd10;
    localparam logic [4:0] AC_JR    = 5'd11;
    localparam logic [4:0] AC_ANDI  = 5'd13;
    localparam logic [4:0] AC_ORI   = 5'd14;
    localparam logic [4:0] AC_SLTI  = 5'd15;
    localparam logic [4:0] AC_ADDI  = 5'd16;
    localparam logic [4:0] AC_ADDIU = 5'd17;
    localparam logic [4:0] AC_LW    = 5'd18;
    localparam logic [4:0] AC_SW    = 5'd19;
    localparam logic [4:0] AC_LUI   = 5'd20;

    function automatic logic uses_mem(input ins_class_t cls);
        return (cls == LW) || (cls == SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_ins_class.sv
// Combinational instruction classifier.
// Ports:
//   ins       in  32  instruction register contents
//   cls       out 3   ins_class_t encoding (ALU_R, ALU_I, LW, SW, JR, NOP, ILLEGAL)
//   alu_code  out 5   ALU operation for this instruction
//   reg_des   out 1   destination select: 0 = rd, 1 = rt
//   alu_sel   out 1   ALU B operand: 0 = rt, 1 = immediate
//   dmem_alu  out 1   writeback source: 1 = memory (lw only)
// Illegal encodings return all-zero controls so nothing leaks onto the datapath.
module ins_class
    import mc_pkg::*;
(
    input  logic [31:0] ins,
    output logic [2:0]  cls,
    output logic [4:0]  alu_code,
    output logic        reg_des,
    output logic        alu_sel,
    output logic        dmem_alu
);

    logic [5:0] op_s;
    logic [5:0] fn_s;

    assign op_s = ins[31:26];
    assign fn_s = ins[5:0];

    // Decode opcode/funct into class and static datapath controls
    always_comb begin
        cls      = ILLEGAL;
        alu_code = AC_ADD;
        reg_des  = 1'b0;
        alu_sel  = 1'b0;
        dmem_alu = 1'b0;
        // The all-zero word is sll $0,$0,0; treat it as a nop before funct decode.
        if (ins == 32'd0) begin
            cls = NOP;
        end else if (op_s == OP_RTYPE) begin
            cls = ALU_R;
            case (fn_s)
                FN_ADD:  alu_code = AC_ADD;
                FN_ADDU: alu_code = AC_ADDU;
                FN_SUB:  alu_code = AC_SUB;
                FN_SUBU: alu_code = AC_SUBU;
                FN_AND:  alu_code = AC_AND;
                FN_OR:   alu_code = AC_OR;
                FN_NOR:  alu_code = AC_NOR;
                FN_SLT:  alu_code = AC_SLT;
                FN_SLL:  alu_code = AC_SLL;
                FN_SRL:  alu_code = AC_SRL;
                FN_SRA:  alu_code = AC_SRA;
                FN_JR: begin
                    cls      = JR;
                    alu_code = AC_JR;
                end
                default: begin
                    cls      = ILLEGAL;
                    alu_code = AC_ADD;
                end
            endcase
        end else begin
            cls     = ALU_I;
            reg_des = 1'b1;
            alu_sel = 1'b1;
            case (op_s)
                OP_ANDI:  alu_code = AC_ANDI;
                OP_ORI:   alu_code = AC_ORI;
                OP_SLTI:  alu_code = AC_SLTI;
                OP_ADDI:  alu_code = AC_ADDI;
                OP_ADDIU: alu_code = AC_ADDIU;
                OP_LUI:   alu_code = AC_LUI;
                OP_LW: begin
                    cls      = LW;
                    alu_code = AC_LW;
                    dmem_alu = 1'b1;
                end
                OP_SW: begin
                    cls      = SW;
                    alu_code = AC_SW;
                end
                default: begin
                    cls      = ILLEGAL;
                    alu_code = AC_ADD;
                    reg_des  = 1'b0;
                    alu_sel  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath over one shared memory port.
// Parameter:
//   TIMEOUT   consecutive wait cycles on one request before halting (1..255)
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   ins                  instruction register contents
//   mem_ready            outstanding memory request completes this cycle
//   mem_req/mem_iord     request valid; address source (0 = PC, 1 = ALU)
//   mem_wen              memory write, only alongside mem_req
//   pc_wen/ir_wen        PC update and IR load strobes
//   reg_wen              register file write strobe
//   reg_des/dmem_alu/alu_sel/alu_code/jr  datapath controls
//   state                current FSM state (debug)
//   halted/timeout       sticky halt flag and timeout cause
//   retired              completed-instruction counter (wraps)
// Every output is forced to zero while rst is high, so a reset landing
// mid-instruction never lets a strobe through in that cycle.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_iord,
    output logic        mem_wen,
    output logic        pc_wen,
    output logic        ir_wen,
    output logic        reg_wen,
    output logic        reg_des,
    output logic        dmem_alu,
    output logic        alu_sel,
    output logic        jr,
    output logic [4:0]  alu_code,
    output logic [2:0]  state,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] retired
);

    // Last counter value before the limit: the wait cycle that sees it is the TIMEOUT-th.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  wait_cnt_r;
    logic [31:0] retired_r;
    logic        halted_r;
    logic        timeout_r;

    logic [2:0]  cls_raw_s;
    ins_class_t  cls_s;
    logic [4:0]  dec_code_s;
    logic        dec_reg_des_s;
    logic        dec_alu_sel_s;
    logic        dec_dmem_alu_s;

    logic        mem_req_s;
    logic        mem_iord_s;
    logic        mem_wen_s;
    logic        pc_wen_s;
    logic        ir_wen_s;
    logic        reg_wen_s;
    logic        jr_s;
    logic        retire_s;
    logic        set_halt_s;
    logic        set_tmo_s;
    logic        tmo_hit_s;
    logic        static_en_s;

    ins_class u_ins_class (
        .ins      (ins),
        .cls      (cls_raw_s),
        .alu_code (dec_code_s),
        .reg_des  (dec_reg_des_s),
        .alu_sel  (dec_alu_sel_s),
        .dmem_alu (dec_dmem_alu_s)
    );

    assign cls_s = ins_class_t'(cls_raw_s);

    // A request stalls out on the cycle that would make the counter reach TIMEOUT;
    // mem_ready in that same cycle takes priority.
    assign tmo_hit_s = ~mem_ready & (wait_cnt_r == TMO_LAST);

    // Next-state and per-state strobes
    always_comb begin
        state_nx_s = state_r;
        mem_req_s  = 1'b0;
        mem_iord_s = 1'b0;
        mem_wen_s  = 1'b0;
        pc_wen_s   = 1'b0;
        ir_wen_s   = 1'b0;
        reg_wen_s  = 1'b0;
        jr_s       = 1'b0;
        retire_s   = 1'b0;
        set_halt_s = 1'b0;
        set_tmo_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_wen_s   = 1'b1;
                    pc_wen_s   = 1'b1;
                    state_nx_s = ST_DECODE;
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_HALT;
                    set_halt_s = 1'b1;
                    set_tmo_s  = 1'b1;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (cls_s)
                    ILLEGAL: begin
                        state_nx_s = ST_HALT;
                        set_halt_s = 1'b1;
                    end
                    NOP: begin
                        state_nx_s = ST_FETCH;
                        retire_s   = 1'b1;
                    end
                    default: state_nx_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (cls_s == JR) begin
                    pc_wen_s   = 1'b1;
                    jr_s       = 1'b1;
                    state_nx_s = ST_FETCH;
                    retire_s   = 1'b1;
                end else if (uses_mem(cls_s)) begin
                    state_nx_s = ST_MEM;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                mem_iord_s = 1'b1;
                mem_wen_s  = (cls_s == SW);
                if (mem_ready) begin
                    if (cls_s == SW) begin
                        state_nx_s = ST_FETCH;
                        retire_s   = 1'b1;
                    end else begin
                        state_nx_s = ST_WB;
                    end
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_HALT;
                    set_halt_s = 1'b1;
                    set_tmo_s  = 1'b1;
                end else begin
                    state_nx_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_wen_s  = 1'b1;
                state_nx_s = ST_FETCH;
                retire_s   = 1'b1;
            end
            ST_HALT: begin
                state_nx_s = ST_HALT;
            end
            default: begin
                // Unused encodings are treated as a fault and parked in HALT.
                state_nx_s = ST_HALT;
                set_halt_s = 1'b1;
            end
        endcase
    end

    // State register, counters and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= 8'd0;
            retired_r  <= 32'd0;
            halted_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            // Count only stalled requests that stay in the same state.
            if (mem_req_s && !mem_ready && (state_nx_s == state_r)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
            halted_r  <= halted_r | set_halt_s;
            timeout_r <= timeout_r | set_tmo_s;
        end
    end

    // Decoded controls are visible only while an instruction is past FETCH.
    assign static_en_s = (state_r == ST_DECODE) || (state_r == ST_EXEC) ||
                         (state_r == ST_MEM)    || (state_r == ST_WB);

    assign mem_req  = mem_req_s  & ~rst;
    assign mem_iord = mem_iord_s & ~rst;
    assign mem_wen  = mem_wen_s  & ~rst;
    assign pc_wen   = pc_wen_s   & ~rst;
    assign ir_wen   = ir_wen_s   & ~rst;
    assign reg_wen  = reg_wen_s  & ~rst;
    assign jr       = jr_s       & ~rst;
    assign reg_des  = dec_reg_des_s  & static_en_s & ~rst;
    assign alu_sel  = dec_alu_sel_s  & static_en_s & ~rst;
    assign dmem_alu = dec_dmem_alu_s & static_en_s & ~rst;
    assign alu_code = (static_en_s && !rst) ? dec_code_s : 5'd0;
    assign state    = rst ? 3'd0 : state_r;
    assign halted   = halted_r  & ~rst;
    assign timeout  = timeout_r & ~rst;
    assign retired  = rst ? 32'd0 : retired_r;

endmodule
